// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: runs one req/ack transaction per memory op against a
// variable-latency data memory, owns the stack pointer used by Push/Pop, and
// freezes the pipeline (bubbling MEM/WB) until each access has completed.
module mem_stage_ctrl #(
  parameter logic [31:0] SP_INIT  = 32'h0000_0FFC,
  parameter int          MAX_WAIT = 8,
  parameter int          CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        PushM,
  input  logic        PopM,
  input  logic        MemSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        FlushW,
  output logic [31:0] ReadDataM,
  output logic [31:0] SP,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             op_push;
  logic             op_pop;
  logic             access;
  logic             req_we;
  logic [31:0]      req_addr;
  logic             misaligned;
  logic             timeout;

  assign access     = MemtoRegM | MemWriteM | PushM | PopM;
  // Push outranks Pop, Pop outranks store; anything else is a load.
  assign req_we     = PushM | (~PopM & MemWriteM);
  assign misaligned = |req_addr[1:0];
  // Last permitted BUSY cycle with no acknowledge in sight.
  assign timeout    = (wait_cnt == CNT_W'(MAX_WAIT - 1)) && !mem_ack;

  // Request address: stack-relative for Push/Pop when MemSrcM selects SP.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    req_addr = ALUResultM;
    if (MemSrcM) begin
      if (PushM)     req_addr = SP - 32'd4;
      else if (PopM) req_addr = SP;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and pipeline freeze/bubble control.
  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    FlushW     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          StallM     = 1'b1;
          FlushW     = 1'b1;
          state_next = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        FlushW = 1'b1;
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request registers, wait counter, read data, stack pointer and error flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      SP        <= SP_INIT;
      mem_err   <= 1'b0;
      wait_cnt  <= '0;
      op_push   <= 1'b0;
      op_pop    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= req_addr;
            mem_we    <= req_we;
            mem_wdata <= WriteDataM;
            op_push   <= PushM;
            op_pop    <= ~PushM & PopM;
            if (misaligned) mem_err <= 1'b1;
            else            mem_req <= 1'b1;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)     ReadDataM <= mem_rdata;
            if (op_push)     SP <= SP - 32'd4;
            else if (op_pop) SP <= SP + 32'd4;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            mem_err   <= 1'b1;
            ReadDataM <= '0;
          end
        end
        DONE:    wait_cnt <= '0;
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed and randomized memory ops
// against a transaction-level model of stack pointer, read data and error flag.
module tb_mem_stage_ctrl;

  localparam logic [31:0] SP_INIT  = 32'h0000_0FFC;
  localparam int          MAX_WAIT = 8;

  logic        CLK;
  logic        reset;
  logic        MemtoRegM, MemWriteM, PushM, PopM, MemSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        StallM, FlushW;
  logic [31:0] ReadDataM, SP;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_sp;
  logic [31:0] m_rd;
  logic        m_err;

  mem_stage_ctrl #(.SP_INIT(SP_INIT), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .PushM(PushM), .PopM(PopM),
    .MemSrcM(MemSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallM(StallM), .FlushW(FlushW), .ReadDataM(ReadDataM), .SP(SP),
    .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle with a non-memory instruction; optional stray ack.
  task automatic idle_cycle(input logic ack);
    @(negedge CLK);
    {MemtoRegM, MemWriteM, PushM, PopM, MemSrcM} = '0;
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    mem_ack    = ack;
    mem_rdata  = $urandom;
    #1;
    check("idle_stall", StallM, 0);
    check("idle_flush", FlushW, 0);
    check("idle_req", mem_req, 0);
    check("idle_rdata", ReadDataM, m_rd);
    check("idle_sp", SP, m_sp);
  endtask

  // Present one memory instruction and answer its request after ack_lat BUSY
  // cycles (0 = never answer). Expectations come from the op rules.
  task automatic run_op(input logic push, input logic pop, input logic store,
                        input logic load, input logic memsrc,
                        input logic [31:0] alu, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_lat);
    logic [31:0] e_addr;
    logic        e_we, mis;
    int          stalls, flushes, busy, e_busy, e_stall;
    bit          done, seen;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;
    e_addr = (memsrc && push) ? m_sp - 32'd4 : (memsrc && pop) ? m_sp : alu;
    e_we   = push || (!pop && store);
    mis    = (e_addr[1:0] != 2'b00);
    stalls = 0; flushes = 0; busy = 0; done = 0; seen = 0;
    seen_addr = '0; seen_wdata = '0; seen_we = 1'b0;

    @(negedge CLK);
    PushM = push; PopM = pop; MemWriteM = store; MemtoRegM = load;
    MemSrcM = memsrc; ALUResultM = alu; WriteDataM = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      mem_ack = 1'b0;
      #1;
      if (!StallM) done = 1;
      else begin
        stalls++;
        if (FlushW) flushes++;
        if (mem_req) begin
          busy++;
          if (!seen) begin
            seen = 1; seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
          end
          if (busy == ack_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
        end
      end
    end
    check("op_complete", 32'(done), 1);

    if (mis) begin
      m_err = 1'b1; e_busy = 0; e_stall = 1;
    end else if (ack_lat >= 1 && ack_lat <= MAX_WAIT) begin
      e_busy = ack_lat; e_stall = 1 + ack_lat;
      if (!e_we) m_rd = rdata;
      if (push)     m_sp = m_sp - 32'd4;
      else if (pop) m_sp = m_sp + 32'd4;
    end else begin
      e_busy = MAX_WAIT; e_stall = 1 + MAX_WAIT;
      m_err = 1'b1; m_rd = '0;
    end

    check("stall_cycles", 32'(stalls), 32'(e_stall));
    check("flush_cycles", 32'(flushes), 32'(e_stall));
    check("req_cycles", 32'(busy), 32'(e_busy));
    if (!mis) begin
      check("req_addr", seen_addr, e_addr);
      check("req_we", 32'(seen_we), 32'(e_we));
      if (e_we) check("req_wdata", seen_wdata, wdata);
    end
    check("done_req", mem_req, 0);
    check("done_rdata", ReadDataM, m_rd);
    check("done_sp", SP, m_sp);
    check("done_err", mem_err, m_err);
    // Stray ack during DONE must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = ~rdata;
  endtask

  initial begin
    int          kind, lat;
    logic [31:0] a;
    bit          got_req;

    reset = 1'b0;
    {MemtoRegM, MemWriteM, PushM, PopM, MemSrcM, mem_ack} = '0;
    ALUResultM = '0; WriteDataM = '0; mem_rdata = '0;
    m_sp = SP_INIT; m_rd = '0; m_err = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_sp", SP, SP_INIT);
    check("rst_err", mem_err, 0);
    check("rst_stall", StallM, 0);
    @(negedge CLK);
    reset = 1'b1;

    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Load from 0x40, ack on first BUSY cycle.
    run_op(0, 0, 0, 1, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1);
    idle_cycle(1'b0);

    // Push then Pop via SP, ack latency 3.
    run_op(1, 0, 0, 0, 1, 32'h0, 32'h1234, 32'h0, 3);
    check("push_sp", SP, 32'h0000_0FF8);
    run_op(0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0000_1234, 3);
    check("pop_sp", SP, 32'h0000_0FFC);
    idle_cycle(1'b1);

    // Walk SP down to 0 with pushes addressed by ALUResultM.
    while (m_sp != 32'h0) begin
      a = $urandom & 32'hFFFF_FFFC;
      run_op(1, 0, 0, 0, 0, a, $urandom, 32'h0, 1);
    end
    check("sp_zero", SP, 32'h0);

    // Push&Pop together at SP=0: push only, wraps to 0xFFFF_FFFC, no error.
    run_op(1, 1, 0, 0, 1, 32'h0, 32'h5555_AAAA, 32'h0, 2);
    check("pushpop_sp", SP, 32'hFFFF_FFFC);
    check("pushpop_err", mem_err, 0);
    // Pop at top of address space wraps SP to 0.
    run_op(0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0BAD_F00D, 1);
    check("popwrap_sp", SP, 32'h0);

    // Store with no ack: timeout sets sticky error.
    run_op(0, 0, 1, 0, 0, 32'h100, 32'hA5A5_A5A5, 32'h0, 0);
    check("timeout_err", mem_err, 1);
    run_op(0, 0, 0, 1, 0, 32'h104, 32'h0, 32'h1357_9BDF, 2);
    check("after_timeout_err", mem_err, 1);

    // Misaligned load: no request, single stall cycle.
    run_op(0, 0, 0, 1, 0, 32'h42, 32'h0, 32'h0, 1);
    idle_cycle(1'b0);

    // Randomized op mix.
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      case (kind)
        0: run_op(0, 0, 0, 1, 0, a, $urandom, $urandom, lat);
        1: run_op(0, 0, 1, 0, 0, a, $urandom, $urandom, lat);
        2: run_op(1, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1), a, $urandom, $urandom, lat);
        3: run_op(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), a, $urandom, $urandom, lat);
        default: run_op(1, 1, 0, 0, $urandom_range(0, 1), a, $urandom, $urandom, lat);
      endcase
      if ($urandom_range(0, 2) == 0) idle_cycle($urandom_range(0, 1));
    end

    // Reset during BUSY with an ack still pending.
    @(negedge CLK);
    {MemtoRegM, MemWriteM, PushM, PopM, MemSrcM} = 5'b10000;
    ALUResultM = 32'h80; mem_ack = 1'b0;
    got_req = 0;
    for (int cyc = 0; cyc < 5 && !got_req; cyc++) begin
      @(negedge CLK);
      #1;
      if (mem_req) got_req = 1;
    end
    check("busy_reached", 32'(got_req), 1);
    reset = 1'b0;
    m_sp = SP_INIT; m_rd = '0; m_err = 1'b0;
    #1;
    check("rst_busy_req", mem_req, 0);
    check("rst_busy_sp", SP, SP_INIT);
    check("rst_busy_rdata", ReadDataM, 0);
    check("rst_busy_err", mem_err, 0);
    MemtoRegM = 1'b0;
    #1;
    check("rst_busy_idle", StallM, 0);
    @(negedge CLK);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    check("late_ack_rdata", ReadDataM, 0);
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", StallM, 0);
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
